// File: rtl/div17x8_seq.sv
// Iterative restoring unsigned divider: NSIZE-bit dividend by DSIZE-bit divisor,
// one quotient bit per clock, start/busy/done handshake with held results.
module div17x8_seq #(
  parameter int unsigned NSIZE = 17,
  parameter int unsigned DSIZE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [NSIZE-1:0] dividend,
  input  logic [DSIZE-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [NSIZE-1:0] quotient,
  output logic [DSIZE-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CntW = $clog2(NSIZE);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StZero
  } state_e;

  state_e state_q, state_d;

  // Working register: dividend bits leave at the top while quotient bits
  // enter at the bottom, so after NSIZE steps it holds the quotient.
  logic [NSIZE-1:0] work_q, work_d;
  logic [DSIZE-1:0] dvs_q, dvs_d;
  logic [DSIZE:0]   part_q, part_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  logic [NSIZE-1:0] quo_q, quo_d;
  logic [DSIZE-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;
  logic             done_q, done_d;

  // One restoring step on the partial remainder.
  logic [DSIZE:0] part_shift;
  logic [DSIZE:0] part_next;
  logic           q_bit;

  always_comb begin
    part_shift = {part_q[DSIZE-1:0], work_q[NSIZE-1]};
    q_bit      = (part_shift >= {1'b0, dvs_q});
    part_next  = q_bit ? (part_shift - {1'b0, dvs_q}) : part_shift;
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    dvs_d   = dvs_q;
    part_d  = part_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (divisor != '0) begin
            state_d = StRun;
            work_d  = dividend;
            dvs_d   = divisor;
            part_d  = '0;
            cnt_d   = CntW'(NSIZE - 1);
          end else begin
            state_d = StZero;
          end
        end
      end

      StRun: begin
        part_d = part_next;
        work_d = {work_q[NSIZE-2:0], q_bit};
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = StIdle;
          done_d  = 1'b1;
          quo_d   = {work_q[NSIZE-2:0], q_bit};
          rem_d   = part_next[DSIZE-1:0];
          dbz_d   = 1'b0;
        end
      end

      StZero: begin
        state_d = StIdle;
        done_d  = 1'b1;
        quo_d   = '1;
        rem_d   = '0;
        dbz_d   = 1'b1;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      work_q  <= '0;
      dvs_q   <= '0;
      part_q  <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      dvs_q   <= dvs_d;
      part_q  <= part_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      done_q  <= done_d;
    end
  end

  assign busy        = (state_q != StIdle);
  assign done        = done_q;
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule
